pdm_mic_ctrl: RTL and testbench
===============================

Name: pdm_mic_ctrl

Overview:
- Sequencing controller for the on-board PDM MEMS microphone.
- Generates the mic clock from the system clock and enforces a start-up warm-up period.
- Samples M_DATA on the edge matching the selected channel and packs bits MSB-first into words for a valid/ready consumer.
- Gates the raw PDM pass-through to the audio output. Sits between the mic pins and the downstream decimation filter / audio PWM path.

Parameters:
- CLK_DIV, 50, M_CLK half-period in clk cycles (100 MHz clk -> 1 MHz M_CLK); legal range >= 2.
- WARMUP_CYCLES, 10000, M_CLK rising edges counted in WARMUP before data is accepted; legal range >= 1.
- WORD_W, 16, PDM bits packed per output word.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a capture session.
- stop  input  1  single-cycle pulse; ends the session.
- lr_sel_cfg  input  1  channel select, latched on an accepted start.
- M_DATA  input  1  mic PDM data.
- M_CLK  output  1  mic clock.
- M_LRSEL  output  1  mic channel select (latched lr_sel_cfg).
- word_data  output  WORD_W  packed PDM word; earliest bit is in the MSB.
- word_valid  output  1  word_data holds an unconsumed word.
- word_ready  input  1  consumer accepts the word when high with word_valid.
- overrun  output  1  sticky; a completed word was dropped.
- busy  output  1  high in WARMUP or RUN.
- audio_on  output  1  high in RUN only.
- audio_pdm  output  1  most recently sampled PDM bit; 0 outside RUN.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register is 0; state is IDLE.
- Divider:
  - Counts 0..CLK_DIV-1 only while in WARMUP or RUN.
  - M_CLK toggles on the clk edge where the count equals CLK_DIV-1, and the count wraps to 0 there.
  - In IDLE, M_CLK is held 0 and the counter is held at 0.
- Sample event: the clk edge on which M_CLK toggles 1->0 if M_LRSEL=0, or 0->1 if M_LRSEL=1. M_DATA is registered on that edge.
- FSM:
  - IDLE: start=1 and stop=0 -> WARMUP. On this transition: latch lr_sel_cfg into M_LRSEL, clear overrun, clear the bit counter and shift register. start with stop in the same cycle -> stay IDLE.
  - WARMUP: count M_CLK rising edges; the WARMUP_CYCLES-th rising edge -> RUN. Samples are discarded. stop -> IDLE on the next clk edge.
  - RUN: on each sample event, shift the bit in and set audio_pdm to that bit. When the WORD_W-th bit arrives:
    - word_valid=0, or a handshake occurs in that same cycle -> load word_data, set word_valid=1.
    - Otherwise -> drop the new word, keep the old one, set overrun=1.
    - Either way the bit counter wraps to 0.
  - RUN with stop: go to IDLE at the next clk edge where M_CLK=0 (immediately if already low). The partial word is discarded, and audio_pdm/audio_on go to 0 on entering IDLE.
  - start while not IDLE is ignored. stop in IDLE is ignored.
- Output handshake: when word_valid and word_ready are both high, the word transfers and word_valid clears on the next edge unless a new word loads in that same cycle. word_valid and word_data persist through the return to IDLE until consumed.
- Latency: a word is presented 1 clk after its last sample event. audio_pdm updates on the sample edge itself (registered).
- Arithmetic: the warm-up counter is $clog2(WARMUP_CYCLES+1) bits, the divider is $clog2(CLK_DIV) bits, and the bit counter is $clog2(WORD_W) bits. There is no saturation; every counter is reset on leaving IDLE.
- Reset mid-session: everything returns to reset values immediately (asynchronous); no word is preserved.

Test Plan (CLK_DIV=2, WARMUP_CYCLES=4, WORD_W=8):
- Reset then idle 50 cycles -> M_CLK constantly 0, busy=0, all outputs 0; start with stop in the same cycle -> remains IDLE.
- start with lr_sel_cfg=0 -> M_CLK period 4 clk; busy=1 at once; audio_on=1 after the 4th M_CLK rise; M_LRSEL=0.
- RUN, M_DATA driven 1,0,1,1,0,0,1,0 at successive falling-edge samples, word_ready=1 -> word_data=8'hB2 and word_valid pulses for 1 clk, one clk after the 8th sample.
- Same session with lr_sel_cfg=1 -> sampling on rising edges, M_LRSEL=1; all-ones data -> word_data=8'hFF.
- word_ready=0 across two completed words -> first word is held, second is dropped, overrun=1; the next start clears overrun.
- stop mid-word (after 3 bits) -> IDLE with M_CLK low, no new word_valid; asserting reset during RUN -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/pdm_mic_ctrl_if.sv
// Word output channel of the PDM mic controller: packed word plus valid/ready.
interface pdm_mic_ctrl_if #(
    parameter int unsigned WORD_W = 16
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/pdm_mic_ctrl.sv
// PDM MEMS mic sequencer: mic clock generation, warm-up gating, edge-selected
// sampling, MSB-first word packing and gated raw PDM pass-through.
module pdm_mic_ctrl #(
    parameter int unsigned CLK_DIV       = 50,
    parameter int unsigned WARMUP_CYCLES = 10000,
    parameter int unsigned WORD_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stop,
    input  logic           lr_sel_cfg,
    input  logic           M_DATA,
    output logic           M_CLK,
    output logic           M_LRSEL,
    output logic           overrun,
    output logic           busy,
    output logic           audio_on,
    output logic           audio_pdm,
    pdm_mic_ctrl_if.master word
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [WARM_W-1:0]   warm_cnt;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [WORD_W-2:0]   shreg;
    logic                stop_pend;

    logic                div_end;
    logic [DIV_W-1:0]    div_cnt_nxt;
    logic                mclk_rise;
    logic                mclk_fall;
    logic                sample_ev;
    logic                handshake;
    logic                go_idle;
    logic [WORD_W-1:0]   new_word;

    // Divider terminal count and the M_CLK edge it produces on this clk edge.
    assign div_end     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign div_cnt_nxt = div_end ? DIV_W'(0) : div_cnt + DIV_W'(1);
    assign mclk_rise   = (state != IDLE) && div_end && !M_CLK;
    assign mclk_fall   = (state != IDLE) && div_end && M_CLK;
    assign sample_ev   = M_LRSEL ? mclk_rise : mclk_fall;
    assign handshake   = word.word_valid && word.word_ready;
    assign new_word    = {shreg, M_DATA};

    // Leaving a session: warm-up stops at once, RUN waits for M_CLK low.
    assign go_idle = ((state == WARMUP) && stop) ||
                     ((state == RUN) && (stop || stop_pend) && !M_CLK);

    // Session FSM, divider, packer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            div_cnt         <= '0;
            warm_cnt        <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            stop_pend       <= 1'b0;
            M_CLK           <= 1'b0;
            M_LRSEL         <= 1'b0;
            overrun         <= 1'b0;
            busy            <= 1'b0;
            audio_on        <= 1'b0;
            audio_pdm       <= 1'b0;
            word.word_data  <= '0;
            word.word_valid <= 1'b0;
        end else begin
            if (handshake) begin
                word.word_valid <= 1'b0;
            end

            if (go_idle) begin
                state     <= IDLE;
                busy      <= 1'b0;
                audio_on  <= 1'b0;
                audio_pdm <= 1'b0;
                M_CLK     <= 1'b0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                stop_pend <= 1'b0;
            end else begin
                if (state != IDLE) begin
                    div_cnt <= div_cnt_nxt;
                    M_CLK   <= M_CLK ^ div_end;
                end

                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state     <= WARMUP;
                            busy      <= 1'b1;
                            M_LRSEL   <= lr_sel_cfg;
                            overrun   <= 1'b0;
                            bit_cnt   <= '0;
                            shreg     <= '0;
                            warm_cnt  <= '0;
                            div_cnt   <= '0;
                            stop_pend <= 1'b0;
                        end
                    end

                    WARMUP: begin
                        if (mclk_rise) begin
                            warm_cnt <= warm_cnt + WARM_W'(1);
                            if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                                state    <= RUN;
                                audio_on <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (stop) begin
                            stop_pend <= 1'b1;
                        end
                        if (sample_ev) begin
                            audio_pdm <= M_DATA;
                            shreg     <= new_word[WORD_W-2:0];
                            if (bit_cnt == BCNT_W'(WORD_W - 1)) begin
                                bit_cnt <= '0;
                                if (!word.word_valid || word.word_ready) begin
                                    word.word_data  <= new_word;
                                    word.word_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BCNT_W'(1);
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Self-checking bench for pdm_mic_ctrl: random data/ready/session timing,
// reference model derived from M_CLK edge arithmetic, word scoreboard.
`timescale 1ns/1ps
module tb_pdm_mic_ctrl;

    localparam int D  = 2;
    localparam int WU = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic stop;
    logic lr_sel_cfg;
    logic m_data;
    logic m_clk;
    logic m_lrsel;
    logic overrun;
    logic busy;
    logic audio_on;
    logic audio_pdm;

    pdm_mic_ctrl_if #(.WORD_W(W)) bus ();

    pdm_mic_ctrl #(
        .CLK_DIV       (D),
        .WARMUP_CYCLES (WU),
        .WORD_W        (W)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .stop       (stop),
        .lr_sel_cfg (lr_sel_cfg),
        .M_DATA     (m_data),
        .M_CLK      (m_clk),
        .M_LRSEL    (m_lrsel),
        .overrun    (overrun),
        .busy       (busy),
        .audio_on   (audio_on),
        .audio_pdm  (audio_pdm),
        .word       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          cyc = 0;
    bit          active = 1'b0;
    int          t0 = 0;
    bit          m_lr = 1'b0;
    bit          stop_req = 1'b0;
    bit          m_pdm = 1'b0;
    bit          m_audio_on = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_overrun = 1'b0;
    logic [W-1:0] m_shreg = '0;
    int          m_nbits = 0;
    logic [W-1:0] sb[$];

    // Monitor results and driver modes
    logic [W-1:0] last_word = '0;
    int           pop_cnt = 0;
    int           ready_mode = 1;
    int           data_mode = 0;
    logic [W-1:0] pat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Is edge e an active sample edge of the current session (RUN only)?
    function automatic bit sample_at(input int e);
        int n;
        if (!active || e <= t0 || ((e - t0) % D) != 0) return 1'b0;
        n = (e - t0) / D;
        return (n >= 2 * WU + int'(m_lr)) && (((n - int'(m_lr)) % 2) == 0);
    endfunction

    function automatic int sample_idx(input int e);
        return ((e - t0) / D - 2 * WU - int'(m_lr)) / 2;
    endfunction

    function automatic bit exp_mclk();
        if (!active) return 1'b0;
        return (((cyc - t0) / D) % 2) == 1;
    endfunction

    function automatic void model_reset();
        active     = 1'b0;
        stop_req   = 1'b0;
        m_lr       = 1'b0;
        m_pdm      = 1'b0;
        m_audio_on = 1'b0;
        m_valid    = 1'b0;
        m_overrun  = 1'b0;
        m_shreg    = '0;
        m_nbits    = 0;
        sb.delete();
    endfunction

    // Reference model: advance one clk edge using what the bench drove.
    always @(posedge clk) begin
        bit hs;
        bit done;
        bit run_before;
        bit mclk_before;
        bit ex;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            hs   = m_valid && bus.word_ready;
            done = 1'b0;
            if (active) begin
                run_before  = (cyc - t0) > D * (2 * WU - 1);
                mclk_before = (((cyc - 1 - t0) / D) % 2) == 1;
                ex = (!run_before && stop) ||
                     (run_before && (stop_req || stop) && !mclk_before);
                if (ex) begin
                    active     = 1'b0;
                    m_pdm      = 1'b0;
                    m_audio_on = 1'b0;
                    stop_req   = 1'b0;
                end else begin
                    if (run_before && stop) stop_req = 1'b1;
                    if (run_before && sample_at(cyc)) begin
                        m_pdm   = m_data;
                        m_shreg = {m_shreg[W-2:0], m_data};
                        m_nbits++;
                        if (m_nbits == W) begin
                            m_nbits = 0;
                            done    = 1'b1;
                        end
                    end
                    if ((cyc - t0) == D * (2 * WU - 1)) m_audio_on = 1'b1;
                end
            end else if (start && !stop) begin
                active    = 1'b1;
                t0        = cyc;
                m_lr      = lr_sel_cfg;
                m_overrun = 1'b0;
                m_shreg   = '0;
                m_nbits   = 0;
                stop_req  = 1'b0;
            end
            if (done) begin
                if (!m_valid || hs) begin
                    sb.push_back(m_shreg);
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    // Drive mic data / consumer ready, then compare outputs and pop words.
    always @(negedge clk) begin
        int nx;
        logic [W-1:0] expw;
        nx = cyc + 1;
        bus.word_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
        if (data_mode == 1 && sample_at(nx)) m_data = pat[W - 1 - (sample_idx(nx) % W)];
        else                                  m_data = 1'($urandom_range(0, 1));
        #1;
        check("M_CLK",      m_clk,          exp_mclk());
        check("busy",       busy,           active);
        check("audio_on",   audio_on,       m_audio_on);
        check("M_LRSEL",    m_lrsel,        m_lr);
        check("audio_pdm",  audio_pdm,      m_pdm);
        check("word_valid", bus.word_valid, m_valid);
        check("overrun",    overrun,        m_overrun);
        if (bus.word_valid && bus.word_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL word_pop: got word %0h expected no word (cycle %0d)", bus.word_data, cyc);
            end else begin
                expw = sb.pop_front();
                check("word_data", bus.word_data, expw);
            end
            last_word = bus.word_data;
            pop_cnt++;
        end
    end

    task automatic pulse_start(input bit lr);
        @(negedge clk);
        lr_sel_cfg = lr;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (pop_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(pop_cnt >= target), 1);
    endtask

    initial begin
        int tgt;
        int k;
        int len;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        lr_sel_cfg = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle: mic clock parked, nothing busy
        repeat (50) @(negedge clk);

        // start and stop together are ignored
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        #2 check("start_stop_idle", busy, 0);

        // Left channel, pattern 1,0,1,1,0,0,1,0
        ready_mode = 1;
        data_mode  = 1;
        pat        = 8'hB2;
        tgt        = pop_cnt + 1;
        pulse_start(1'b0);
        #2 check("busy_at_start", busy, 1);
        check("lrsel_0", m_lrsel, 0);
        wait_words(tgt, 200, "wait_word_b2");
        #2 check("word_b2", last_word, 8'hB2);
        pulse_stop();
        repeat (8) @(negedge clk);

        // Right channel, all ones
        pat = 8'hFF;
        tgt = pop_cnt + 1;
        pulse_start(1'b1);
        #2 check("lrsel_1", m_lrsel, 1);
        wait_words(tgt, 200, "wait_word_ff");
        #2 check("word_ff", last_word, 8'hFF);
        pulse_stop();
        repeat (8) @(negedge clk);

        // Consumer stalled across two words: hold first, drop second
        data_mode  = 0;
        ready_mode = 0;
        pulse_start(1'($urandom_range(0, 1)));
        repeat (90) @(negedge clk);
        #2 check("overrun_set", overrun, 1);
        check("held_valid", bus.word_valid, 1);
        ready_mode = 1;
        repeat (3) @(negedge clk);
        pulse_stop();
        repeat (6) @(negedge clk);
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        #2 check("overrun_cleared", overrun, 0);

        // Stop after three bits of a word
        pulse_stop();
        repeat (6) @(negedge clk);
        pulse_start(1'b0);
        k = 0;
        while (m_nbits != 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_3_bits", 32'(m_nbits), 3);
        tgt = pop_cnt;
        pulse_stop();
        repeat (6) @(negedge clk);
        #2 check("stop_busy", busy, 0);
        check("stop_mclk", m_clk, 0);
        check("stop_no_word", 32'(pop_cnt), 32'(tgt));

        // Random sessions: stray starts/stops, random ready, random lengths
        for (int s = 0; s < 12; s++) begin
            ready_mode = (s % 4 == 0) ? 0 : 2;
            if ($urandom_range(0, 1) == 1) pulse_stop();
            pulse_start(1'($urandom_range(0, 1)));
            len = $urandom_range(2, 160);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 15) == 0) begin
                    start      = 1'b1;
                    lr_sel_cfg = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            pulse_stop();
            ready_mode = 1;
            repeat (12) @(negedge clk);
        end

        // Asynchronous reset in the middle of RUN
        ready_mode = 2;
        pulse_start(1'b1);
        repeat (40) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mclk",   m_clk,          0);
        check("rst_lrsel",  m_lrsel,        0);
        check("rst_busy",   busy,           0);
        check("rst_audio",  audio_on,       0);
        check("rst_pdm",    audio_pdm,      0);
        check("rst_ovr",    overrun,        0);
        check("rst_valid",  bus.word_valid, 0);
        check("rst_data",   32'(bus.word_data), 0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        ready_mode = 1;
        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
